// File: rtl/mux2_bus_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the shared resource.
// The arbiter sits on the slave modport; the requester/resource side drives the master modport.
interface mux2_bus_arbiter_if #(
  parameter int bitwidth = 32
);
  logic                req_a;
  logic                req_b;
  logic [bitwidth-1:0] a_data;
  logic [bitwidth-1:0] b_data;
  logic                res_ready;
  logic                sel;
  logic [bitwidth-1:0] y;
  logic                res_valid;
  logic                ack_a;
  logic                ack_b;
  logic                err_a;
  logic                err_b;

  modport master (
    output req_a, req_b, a_data, b_data, res_ready,
    input  sel, y, res_valid, ack_a, ack_b, err_a, err_b
  );

  modport slave (
    input  req_a, req_b, a_data, b_data, res_ready,
    output sel, y, res_valid, ack_a, ack_b, err_a, err_b
  );
endinterface

// File: rtl/mux2_bus_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 datapath mux, with
// completion acks and per-grant timeout abort.
module mux2_bus_arbiter #(
  parameter int bitwidth = 32,
  parameter int TIMEOUT  = 16
) (
  input logic               clk,
  input logic               reset,
  mux2_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic       vld_q, vld_d;
  logic       last_q, last_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       in_a, in_b, tmo, fin;

  assign in_a = (state_q == GNT_A);
  assign in_b = (state_q == GNT_B);
  // Completion takes priority: a timeout only counts on a non-ready cycle.
  assign tmo  = (TIMEOUT != 0) && !bus.res_ready && (wait_cnt_q == TO_LAST);
  assign fin  = (in_a || in_b) && (bus.res_ready || tmo);

  assign bus.ack_a     = in_a && bus.res_ready;
  assign bus.ack_b     = in_b && bus.res_ready;
  assign bus.err_a     = in_a && tmo;
  assign bus.err_b     = in_b && tmo;
  assign bus.sel       = sel_q;
  assign bus.res_valid = vld_q;
  assign bus.y         = sel_q ? bus.b_data : bus.a_data;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        wait_cnt_d = 8'd0;
        if (bus.req_a && (!bus.req_b || last_q)) state_d = GNT_A;
        else if (bus.req_b)                      state_d = GNT_B;
      end
      GNT_A: begin
        if (fin) begin
          last_d     = 1'b0;
          wait_cnt_d = 8'd0;
          // Hand over to the other side first so neither requester starves.
          state_d    = bus.req_b ? GNT_B : (bus.req_a ? GNT_A : IDLE);
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      GNT_B: begin
        if (fin) begin
          last_d     = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = bus.req_a ? GNT_A : (bus.req_b ? GNT_B : IDLE);
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    sel_d = (state_d == GNT_B) ? 1'b1 : ((state_d == GNT_A) ? 1'b0 : sel_q);
    vld_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      vld_q      <= 1'b0;
      last_q     <= 1'b1;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// Directed-vector bench: three arbiters (TIMEOUT 16, 4, 0) share one stimulus set.
module tb_mux2_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, res_ready;
  logic [31:0] a_data, b_data;
  int          n_vec = 0;
  int          n_err = 0;

  localparam logic [31:0] WA = 32'h1111_1111;
  localparam logic [31:0] WB = 32'h2222_2222;

  always #5 clk = ~clk;

  mux2_bus_arbiter_if #(.bitwidth(32)) b16 ();
  mux2_bus_arbiter_if #(.bitwidth(32)) b4 ();
  mux2_bus_arbiter_if #(.bitwidth(32)) b0 ();

  assign b16.req_a = req_a;  assign b16.req_b = req_b;  assign b16.res_ready = res_ready;
  assign b16.a_data = a_data; assign b16.b_data = b_data;
  assign b4.req_a  = req_a;  assign b4.req_b  = req_b;  assign b4.res_ready  = res_ready;
  assign b4.a_data  = a_data; assign b4.b_data  = b_data;
  assign b0.req_a  = req_a;  assign b0.req_b  = req_b;  assign b0.res_ready  = res_ready;
  assign b0.a_data  = a_data; assign b0.b_data  = b_data;

  mux2_bus_arbiter #(.bitwidth(32), .TIMEOUT(16)) u16 (.clk(clk), .reset(reset), .bus(b16));
  mux2_bus_arbiter #(.bitwidth(32), .TIMEOUT(4))  u4  (.clk(clk), .reset(reset), .bus(b4));
  mux2_bus_arbiter #(.bitwidth(32), .TIMEOUT(0))  u0  (.clk(clk), .reset(reset), .bus(b0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to mid-cycle after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; res_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    a_data = WA; b_data = WB;
    do_reset();
    #1;
    chk("rst_sel",   {31'd0, b16.sel}, 32'd0);
    chk("rst_valid", {31'd0, b16.res_valid}, 32'd0);
    chk("rst_acks",  {28'd0, b16.ack_a, b16.ack_b, b16.err_a, b16.err_b}, 32'd0);
    chk("rst_y",     b16.y, WA);

    // Single A transfer, ready immediately.
    req_a = 1'b1; res_ready = 1'b1; #1;
    chk("a1_idle_valid", {31'd0, b16.res_valid}, 32'd0);
    chk("a1_idle_ack",   {31'd0, b16.ack_a}, 32'd0);
    tick();
    req_a = 1'b0; #1;
    chk("a1_valid", {31'd0, b16.res_valid}, 32'd1);
    chk("a1_sel",   {31'd0, b16.sel}, 32'd0);
    chk("a1_y",     b16.y, WA);
    chk("a1_ack",   {28'd0, b16.ack_a, b16.ack_b, b16.err_a, b16.err_b}, 32'h8);
    tick(); #1;
    chk("a1_back_idle", {31'd0, b16.res_valid}, 32'd0);
    chk("a1_ack_gone",  {31'd0, b16.ack_a}, 32'd0);

    // Both requesting, always ready: strict alternation starting with A.
    do_reset();
    req_a = 1'b1; req_b = 1'b1; res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      chk("rr_valid", {31'd0, b16.res_valid}, 32'd1);
      chk("rr_sel",   {31'd0, b16.sel}, 32'(k % 2));
      chk("rr_y",     b16.y, (k % 2 == 1) ? WB : WA);
      chk("rr_acks",  {30'd0, b16.ack_a, b16.ack_b}, (k % 2 == 1) ? 32'd1 : 32'd2);
    end

    // B alone, never ready: err_b on grant cycle 16, then a fresh grant restarts the count.
    do_reset();
    req_b = 1'b1; res_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 16; k++) begin
        tick(); #1;
        chk("to16_valid", {31'd0, b16.res_valid}, 32'd1);
        chk("to16_sel",   {31'd0, b16.sel}, 32'd1);
        chk("to16_err",   {30'd0, b16.err_b, b16.ack_b}, (k == 16) ? 32'd2 : 32'd0);
      end
    end
    req_b = 1'b0;
    tick(); #1;
    chk("to16_idle", {31'd0, b16.res_valid}, 32'd0);

    // TIMEOUT=4: ready arriving in the 4th grant cycle completes, no error.
    do_reset();
    req_a = 1'b1; res_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(); #1;
      chk("to4_wait", {30'd0, b4.ack_a, b4.err_a}, 32'd0);
    end
    tick();
    res_ready = 1'b1; req_a = 1'b0; #1;
    chk("to4_ack_wins", {30'd0, b4.ack_a, b4.err_a}, 32'd2);
    tick();
    // Same again without ready: the 4th cycle aborts.
    req_a = 1'b1; res_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(); #1;
      chk("to4_abort", {30'd0, b4.ack_a, b4.err_a}, (k == 4) ? 32'd1 : 32'd0);
    end
    req_a = 1'b0;

    // Reset mid-grant, then A wins the pending tie.
    do_reset();
    req_b = 1'b1; res_ready = 1'b0;
    tick(); tick(); #1;
    chk("mid_gntb_sel", {31'd0, b16.sel}, 32'd1);
    reset = 1'b1; req_a = 1'b1;
    tick(); #1;
    reset = 1'b0;
    chk("mid_rst_sel",   {31'd0, b16.sel}, 32'd0);
    chk("mid_rst_valid", {31'd0, b16.res_valid}, 32'd0);
    chk("mid_rst_pulse", {28'd0, b16.ack_a, b16.ack_b, b16.err_a, b16.err_b}, 32'd0);
    tick(); #1;
    chk("mid_first_a_sel",   {31'd0, b16.sel}, 32'd0);
    chk("mid_first_a_valid", {31'd0, b16.res_valid}, 32'd1);

    // TIMEOUT=0: grant is held indefinitely, no error, then ack.
    do_reset();
    req_a = 1'b1; res_ready = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      tick(); #1;
      chk("to0_hold", {29'd0, b0.res_valid, b0.err_a, b0.ack_a}, 32'd4);
    end
    res_ready = 1'b1; req_a = 1'b0; #1;
    chk("to0_ack", {30'd0, b0.ack_a, b0.err_a}, 32'd2);
    tick(); #1;
    chk("to0_idle", {31'd0, b0.res_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
